// File: rtl/strassen_result_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module   : strassen_result_streamer_if
//  Purpose  : Valid/ready element stream carrying one matrix element per beat
//             together with its row/column indices and frame markers.
//  Revision : 1.0 - initial release
// ============================================================================
interface strassen_result_streamer_if #(
   parameter int N = 16,
   parameter int W = 16
);
   localparam int LOG2N = $clog2(N);

   logic                    m_valid;
   logic                    m_ready;
   logic signed [W-1:0]     m_data;
   logic        [LOG2N-1:0] m_row;
   logic        [LOG2N-1:0] m_col;
   logic                    m_last;
   logic                    m_sum;

   // Producer side: drives the beat, observes downstream readiness
   modport master (
      output m_valid, m_data, m_row, m_col, m_last, m_sum,
      input  m_ready
   );

   // Consumer side: observes the beat, drives readiness
   modport slave (
      input  m_valid, m_data, m_row, m_col, m_last, m_sum,
      output m_ready
   );
endinterface
`default_nettype wire

// File: rtl/strassen_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : strassen_result_streamer
//  Purpose  : Snapshots the N x N signed result matrix of the Strassen
//             multiplier on its done pulse and streams it out row-major, one
//             element per beat, over a registered valid/ready interface.
//  Options  : define STRASSEN_STREAM_CHECKSUM_EN to append a checksum beat
//             (sum of all elements, modulo 2^W) after element (N-1,N-1).
//  Revision : 1.0 - initial release
// ============================================================================
module strassen_result_streamer #(
   parameter int N = 16,
   parameter int W = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        done,
   input  logic signed [W-1:0]         C [0:N-1][0:N-1],
   strassen_result_streamer_if.master  m_if,
   output logic                        busy,
   output logic                        drop_err
);

   localparam int LOG2N = $clog2(N);
   // N is a power of two, so the last row/column index is all ones
   localparam logic [LOG2N-1:0] c_IDX_MAX = '1;

`ifdef STRASSEN_STREAM_CHECKSUM_EN
   localparam int   ACC_W          = W + 2 * LOG2N;
   localparam logic c_LAST_ON_ELEM = 1'b0;
`else
   localparam logic c_LAST_ON_ELEM = 1'b1;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_SUM    = 2'd2
   } state_t;

   state_t                  r_state;
   logic                    r_valid;
   logic signed [W-1:0]     r_data;
   logic        [LOG2N-1:0] r_row;
   logic        [LOG2N-1:0] r_col;
   logic                    r_last;
   logic                    r_drop_err;
   logic signed [W-1:0]     r_buf [0:N-1][0:N-1];

   logic                    w_xfer;
   logic                    w_last_elem;
   logic        [LOG2N-1:0] w_nxt_row;
   logic        [LOG2N-1:0] w_nxt_col;
   logic                    w_final_xfer;
   logic                    w_capture;
   logic                    w_drop;

`ifdef STRASSEN_STREAM_CHECKSUM_EN
   logic                    r_sum;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_acc_next;

   // Running sum including the element currently on the bus
   assign w_acc_next   = r_acc + {{(2 * LOG2N){r_data[W-1]}}, r_data};
   assign w_final_xfer = (r_state == S_SUM) && w_xfer;
`else
   assign w_final_xfer = (r_state == S_STREAM) && w_xfer && w_last_elem;
`endif

   assign w_xfer      = r_valid && m_if.m_ready;
   assign w_last_elem = (r_row == c_IDX_MAX) && (r_col == c_IDX_MAX);
   assign w_nxt_col   = r_col + 1'b1;
   assign w_nxt_row   = (r_col == c_IDX_MAX) ? r_row + 1'b1 : r_row;

   // A done in the frame's final transfer cycle chains straight into the next
   // frame; any other done while a frame is in flight is dropped.
   assign w_capture = done && ((r_state == S_IDLE) || w_final_xfer);
   assign w_drop    = done && !w_capture;

   // Snapshot the result matrix; C is ignored outside a capture cycle
   always_ff @(posedge clk) begin
      if (!rst && w_capture) begin
         r_buf <= C;
      end
   end

   // Frame sequencer with registered stream outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_last     <= 1'b0;
         r_drop_err <= 1'b0;
`ifdef STRASSEN_STREAM_CHECKSUM_EN
         r_sum      <= 1'b0;
         r_acc      <= '0;
`endif
      end else begin
         if (w_drop) begin
            r_drop_err <= 1'b1;
         end

         if (w_capture) begin
            // Present element (0,0) straight from C; the buffer fills this edge
            r_state <= S_STREAM;
            r_valid <= 1'b1;
            r_data  <= C[0][0];
            r_row   <= '0;
            r_col   <= '0;
            r_last  <= 1'b0;
`ifdef STRASSEN_STREAM_CHECKSUM_EN
            r_sum   <= 1'b0;
            r_acc   <= '0;
`endif
         end else begin
            case (r_state)
               S_STREAM: begin
                  if (w_xfer) begin
`ifdef STRASSEN_STREAM_CHECKSUM_EN
                     r_acc <= w_acc_next;
`endif
                     if (w_last_elem) begin
`ifdef STRASSEN_STREAM_CHECKSUM_EN
                        r_state <= S_SUM;
                        r_data  <= w_acc_next[W-1:0];
                        r_row   <= '0;
                        r_col   <= '0;
                        r_last  <= 1'b1;
                        r_sum   <= 1'b1;
`else
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_data  <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_last  <= 1'b0;
`endif
                     end else begin
                        r_row  <= w_nxt_row;
                        r_col  <= w_nxt_col;
                        r_data <= r_buf[w_nxt_row][w_nxt_col];
                        r_last <= c_LAST_ON_ELEM &&
                                  (w_nxt_row == c_IDX_MAX) &&
                                  (w_nxt_col == c_IDX_MAX);
                     end
                  end
               end
`ifdef STRASSEN_STREAM_CHECKSUM_EN
               S_SUM: begin
                  if (w_xfer) begin
                     r_state <= S_IDLE;
                     r_valid <= 1'b0;
                     r_data  <= '0;
                     r_last  <= 1'b0;
                     r_sum   <= 1'b0;
                  end
               end
`endif
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign m_if.m_valid = r_valid;
   assign m_if.m_data  = r_data;
   assign m_if.m_row   = r_row;
   assign m_if.m_col   = r_col;
   assign m_if.m_last  = r_last;
`ifdef STRASSEN_STREAM_CHECKSUM_EN
   assign m_if.m_sum   = r_sum;
`else
   assign m_if.m_sum   = 1'b0;
`endif
   assign busy         = (r_state != S_IDLE);
   assign drop_err     = r_drop_err;

endmodule
`default_nettype wire

// File: doc/strassen_result_streamer.md
# strassen_result_streamer

Receive-side companion to `strassen_matrix_mult`. On the multiplier's `done` pulse it snapshots the full N×N signed result matrix `C`, then streams the elements out one per beat in row-major order over a valid/ready interface. The multiplier is free to start a new product as soon as `done` has been sampled. The stream feeds downstream consumers such as a UART/DMA egress or the fitness evaluator.

## Interface
- `N`, default 16: matrix dimension; must be a power of two, ≥2.
- `W`, default 16: element width, signed two's complement.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `done`  in  1: one-cycle pulse from the multiplier; `C` is valid in the same cycle.
- `C`  in  signed [W-1:0] [0:N-1][0:N-1]: result matrix, sampled only when a capture occurs.
- `m_valid`  out  1: output beat valid.
- `m_ready`  in  1: downstream accepts the beat.
- `m_data`  out  signed [W-1:0]: element value, or the checksum on the sum beat.
- `m_row`  out  [$clog2(N)-1:0]: row index of the current element.
- `m_col`  out  [$clog2(N)-1:0]: column index of the current element.
- `m_last`  out  1: final beat of the frame.
- `m_sum`  out  1: current beat is the checksum beat (constant 0 without the macro).
- `busy`  out  1: a frame is captured and not yet fully transferred.
- `drop_err`  out  1: sticky flag; a `done` was ignored because the block was busy.

## Operation
- States: IDLE, STREAM, SUM (SUM exists only with the macro).
- **IDLE.**
  - `done`=1: copy all of `C` into the internal buffer, set row=col=0, clear the accumulator, and go to STREAM.
- **STREAM.**
  - `m_valid`=1, `m_data`=buf[row][col], `m_row`/`m_col` show the indices.
  - A transfer is any cycle with `m_valid && m_ready`.
  - On a transfer, col increments. When col wraps from N-1 to 0, row increments.
  - On the transfer of element (N-1,N-1):
    - without the macro: go to IDLE;
    - with the macro: go to SUM.
- **SUM.**
  - `m_valid`=1, `m_sum`=1, `m_last`=1, `m_data`=checksum, `m_row`=`m_col`=0.
  - On a transfer, go to IDLE.
- **`m_last`.**
  - Without the macro: asserted only on element (N-1,N-1).
  - With the macro: asserted only on the SUM beat.
- **Holding rule.** While `m_valid && !m_ready`, all `m_*` outputs hold stable. `m_valid` never drops without a transfer, except on reset.
- **`busy`.** Equals (state != IDLE).
- **`done` while busy.** It is ignored and `drop_err` is set to 1. The in-flight frame is unaffected.
  - Exception: a `done` in the same cycle as the frame's final transfer is accepted as a new capture, giving back-to-back frames with no IDLE cycle. `drop_err` is not set in this case.
- **`drop_err`.** Cleared only by `rst`.
- **Buffer isolation.** Changes on `C` outside a capture cycle have no effect.

## Timing
- **Reset values.** After a clock edge with `rst`=1, the following are all 0:
  - `m_valid`, `m_data`, `m_row`, `m_col`, `m_last`, `m_sum`, `busy`, `drop_err`;
  - the state (IDLE) and the accumulator.
  - Reset has priority over `done` and over any transfer.
- **Reset mid-frame.** The frame is discarded; `m_valid`=0 from the next cycle.
- **Latency.** `done` sampled at edge k gives `m_valid`=1 and element (0,0) from edge k to edge k+1. There is no combinational path from `done` or `C` to the outputs.
- **Throughput.** One element per cycle with `m_ready` held high.
  - Frame length is N² cycles, or N²+1 with the macro.
- **Ready path.** `m_ready` has no combinational path to the `m_*` outputs; all outputs are registered.
- **Arithmetic.** The checksum is the sum of all N² elements, accumulated at each STREAM transfer.
  - Accumulated in W+2·log2(N) bits.
  - `m_data` carries the low W bits, i.e. wrap-around modulo 2^W, as two's complement.

## Configuration
- Macro: `STRASSEN_STREAM_CHECKSUM_EN`.
- **Defined.** The accumulator and SUM state are built. Each frame ends with one extra checksum beat (`m_sum`=1, `m_last`=1).
- **Undefined.** No accumulator and no SUM state. `m_sum` is tied to 0 and the frame ends on element (N-1,N-1).

## Test plan
- **Reset values.** Hold `rst` for 2 cycles with `done`=1. Then:
  - all outputs are 0;
  - no capture occurs.
- **Basic frame.** Set C[r][c]=r·16+c and pulse `done` with `m_ready`=1. Then:
  - 256 consecutive beats start the cycle after `done`, with `m_data`=0..255 and matching `m_row`/`m_col`;
  - `m_last` is asserted only on the beat with value 255 (macro off).
  - With the macro on, one further beat follows: `m_data`=0x7F80 (32640), `m_sum`=1, `m_last`=1.
- **Negative checksum (macro on).** Set all C=-1. The checksum beat carries `m_data`=0xFF00 (-256).
- **Backpressure and isolation.** Drive `m_ready` in the pattern 1,0,0,1,0,1… and change `C` randomly after capture. Then:
  - outputs hold stable during stalls;
  - the captured values stream out in order with no loss or duplication;
  - `busy` stays 1 until the final transfer.
- **`done` during a frame.**
  - A `done` pulse at beat 100 sets `drop_err`=1 and leaves the frame intact.
  - A `done` in the cycle of the final transfer starts a new frame: its (0,0) beat appears on the next cycle and `drop_err` remains 0.
- **Reset mid-frame.** Assert `rst` at beat 50. Then:
  - `m_valid`=0 and `drop_err`=0 on the next cycle;
  - a subsequent `done` restarts the stream at element (0,0).
